muldiv_sequencer: RTL and testbench

- Multi-cycle iterative unsigned multiply/divide unit with its own sequencing FSM for the 16-bit CPU.
- Serves the MUL (opcode 0010) and DIV (opcode 0011) instructions in place of a single-cycle ALU path.
- Drives a stall line so the core freezes the pipeline until the result is written back.
- Datapath: shift-add multiply, restoring divide, one bit per cycle.

---
 rtl/muldiv_sequencer.sv | 167 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per cycle, with stall control.
// Optional: define MULDIV_EARLY_EXIT_EN to end MUL once the multiplier runs out of set bits.
module muldiv_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             done,
  output logic             busy,
  output logic             stall,
  output logic             div_zero
);

  // state | meaning
  // IDLE  | waiting for an accepted MUL/DIV issue
  // MUL   | one shift-add iteration per cycle
  // DIV   | one restoring-divide iteration per cycle
  // DONE  | single cycle, done=1, results valid

  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} stateT;

  stateT            state;
  logic [CNT_W-1:0] cnt;
  logic [2*WIDTH-1:0] acc;   // MUL: accumulator; DIV: {remainder, quotient}
  logic [WIDTH-1:0] mplr;
  logic [WIDTH-1:0] opReg;   // multiplicand or divisor

  logic issueMul, issueDiv, accept;
  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] mulAcc, mulOut;
  logic [WIDTH-1:0]   mulMplr;
  logic               mulLast, lastIter;
  logic [WIDTH:0]     divShift;
  logic               divFit;
  logic [WIDTH-1:0]   divRem;
  logic [2*WIDTH-1:0] divAcc;

  assign issueMul = (state == IDLE) && start && !flush && (opcode == OP_MUL);
  assign issueDiv = (state == IDLE) && start && !flush && (opcode == OP_DIV);
  assign accept   = issueMul || issueDiv;
  assign stall    = (state == MUL) || (state == DIV) || accept;
  assign lastIter = (cnt == CNT_W'(1));

  always_comb begin
    mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplr[0] ? {1'b0, opReg} : '0);
    mulAcc   = {mulSum, acc[WIDTH-1:1]};
    mulMplr  = mplr >> 1;
`ifdef MULDIV_EARLY_EXIT_EN
    mulLast  = lastIter || (mulMplr == '0);
    // skipped iterations would only have shifted the accumulator right
    mulOut   = mulAcc >> (cnt - CNT_W'(1));
`else
    mulLast  = lastIter;
    mulOut   = mulAcc;
`endif
    divShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    divFit   = divShift >= {1'b0, opReg};
    divRem   = divShift[WIDTH-1:0] - opReg;
    divAcc   = {(divFit ? divRem : divShift[WIDTH-1:0]), acc[WIDTH-2:0], divFit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      mplr      <= '0;
      opReg     <= '0;
      result_lo <= '0;
      result_hi <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (issueMul) begin
            div_zero <= 1'b0;
            busy     <= 1'b1;
`ifdef MULDIV_EARLY_EXIT_EN
            if (op_b == '0) begin
              result_lo <= '0;
              result_hi <= '0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              acc   <= '0;
              opReg <= op_a;
              mplr  <= op_b;
              cnt   <= CNT_W'(WIDTH);
              state <= MUL;
            end
`else
            acc   <= '0;
            opReg <= op_a;
            mplr  <= op_b;
            cnt   <= CNT_W'(WIDTH);
            state <= MUL;
`endif
          end else if (issueDiv) begin
            busy <= 1'b1;
            if (op_b == '0) begin
              result_lo <= '1;
              result_hi <= op_a;
              div_zero  <= 1'b1;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              div_zero <= 1'b0;
              acc      <= {{WIDTH{1'b0}}, op_a};
              opReg    <= op_b;
              cnt      <= CNT_W'(WIDTH);
              state    <= DIV;
            end
          end
        end
        MUL: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            acc  <= mulAcc;
            mplr <= mulMplr;
            cnt  <= cnt - CNT_W'(1);
            if (mulLast) begin
              {result_hi, result_lo} <= mulOut;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DIV: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            acc <= divAcc;
            cnt <= cnt - CNT_W'(1);
            if (lastIter) begin
              result_lo <= divAcc[WIDTH-1:0];
              result_hi <= divAcc[2*WIDTH-1:WIDTH];
              done      <= 1'b1;
              state     <= DONE;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed cases plus random MUL/DIV against an arithmetic model.
// Latency expectations follow MULDIV_EARLY_EXIT_EN when it is defined.
module tb_muldiv_sequencer;

  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;

  logic        clk = 1'b0;
  logic        rstN;
  logic        start;
  logic [3:0]  opcode;
  logic [15:0] opA, opB;
  logic        flush;
  logic [15:0] resultLo, resultHi;
  logic        done, busy, stall, divZero;

  int checks = 0;
  int failures = 0;
  logic [15:0] lastLo = '0, lastHi = '0;
  logic        lastDz = 1'b0;

  muldiv_sequencer #(.WIDTH(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rstN), .start(start), .opcode(opcode), .op_a(opA), .op_b(opB),
    .flush(flush), .result_lo(resultLo), .result_hi(resultHi), .done(done), .busy(busy),
    .stall(stall), .div_zero(divZero)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one operation at the next negedge and follow it to completion.
  task automatic runOp(input logic [3:0] opc, input logic [15:0] a, input logic [15:0] b, input bit poke);
    logic [31:0] prod;
    logic [15:0] expLo, expHi;
    logic        expDz;
    int          lat, cyc, badCyc, hb;
    bit          seen;
    if (opc == OP_MUL) begin
      prod  = 32'(a) * 32'(b);
      expLo = prod[15:0];
      expHi = prod[31:16];
      expDz = 1'b0;
`ifdef MULDIV_EARLY_EXIT_EN
      hb = 0;
      for (int i = 0; i < 16; i++) if (b[i]) hb = i;
      lat = (b == 16'd0) ? 1 : hb + 2;
`else
      hb  = 0;
      lat = 17;
`endif
    end else begin
      hb = 0;
      if (b == 16'd0) begin
        expLo = 16'hFFFF; expHi = a; expDz = 1'b1; lat = 1;
      end else begin
        expLo = a / b; expHi = a % b; expDz = 1'b0; lat = 17;
      end
    end
    @(negedge clk);
    start = 1'b1; opcode = opc; opA = a; opB = b;
    #1 checkVal("stall_issue", 32'(stall), 32'd1);
    @(negedge clk);
    start = 1'b0;
    cyc = 1; seen = 0; badCyc = 0;
    while (cyc <= 40 && !seen) begin
      #1;
      if (done) seen = 1;
      else begin
        if (!(stall && busy)) badCyc++;
        @(negedge clk);
        cyc++;
      end
    end
    checkVal("done_seen", 32'(seen), 32'd1);
    if (seen) begin
      checkVal("latency", 32'(cyc), 32'(lat));
      checkVal("stall_busy_run", 32'(badCyc), 32'd0);
      checkVal("result_lo", 32'(resultLo), 32'(expLo));
      checkVal("result_hi", 32'(resultHi), 32'(expHi));
      checkVal("div_zero", 32'(divZero), 32'(expDz));
      checkVal("busy_done", 32'(busy), 32'd1);
      if (poke) begin
        start = 1'b1; opcode = OP_MUL; opA = 16'h1111; opB = 16'h2222;
        #1;
      end
      checkVal("stall_done", 32'(stall), 32'd0);
      @(negedge clk);
      start = 1'b0;
      #1;
      checkVal("done_pulse", 32'(done), 32'd0);
      checkVal("busy_after", 32'(busy), 32'd0);
      checkVal("hold_lo", 32'(resultLo), 32'(expLo));
      lastLo = expLo; lastHi = expHi; lastDz = expDz;
    end
  endtask

  task automatic runFlush(input logic [15:0] a);
    int sawDone;
    @(negedge clk);
    start = 1'b1; opcode = OP_MUL; opA = a; opB = 16'hFFFF;
    sawDone = 0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      if (c == 5) begin start = 1'b1; opcode = OP_DIV; opA = 16'd9; opB = 16'd3; end
      if (c == 8) flush = 1'b1;
      #1;
      if (done) sawDone++;
      if (c == 5) checkVal("stall_second_start", 32'(stall), 32'd1);
    end
    checkVal("flush_busy", 32'(busy), 32'd0);
    checkVal("flush_stall", 32'(stall), 32'd0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      if (done || busy) sawDone++;
    end
    checkVal("flush_no_done", 32'(sawDone), 32'd0);
    checkVal("flush_keep_lo", 32'(resultLo), 32'(lastLo));
    checkVal("flush_keep_hi", 32'(resultHi), 32'(lastHi));
    checkVal("flush_keep_dz", 32'(divZero), 32'(lastDz));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra, rb;
    logic [3:0]  badOp;
    rstN = 1'b0; start = 1'b0; opcode = 4'd0; opA = '0; opB = '0; flush = 1'b0;
    #3;
    checkVal("rst_lo", 32'(resultLo), 32'd0);
    checkVal("rst_hi", 32'(resultHi), 32'd0);
    checkVal("rst_flags", 32'({done, busy, stall, divZero}), 32'd0);
    @(negedge clk);
    rstN = 1'b1;

    runOp(OP_MUL, 16'd3, 16'd5, 0);
    runOp(OP_MUL, 16'hFFFF, 16'hFFFF, 1);
    runOp(OP_MUL, 16'h1234, 16'h0002, 0);
    runOp(OP_MUL, 16'h1234, 16'h0000, 0);
    runOp(OP_DIV, 16'd100, 16'd7, 0);
    runOp(OP_DIV, 16'hFFFF, 16'd1, 1);
    runOp(OP_DIV, 16'h1234, 16'd0, 0);
    runOp(OP_DIV, 16'd5, 16'd9, 0);

    // start with a non-MUL/DIV opcode, and flush colliding with start, must not issue
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      badOp = 4'($urandom_range(0, 15));
      if (badOp == OP_MUL || badOp == OP_DIV) badOp = 4'hF;
      start = 1'b1; opcode = (i == 3) ? OP_MUL : badOp; flush = (i == 3);
      #1 checkVal("ignored_stall", 32'(stall), 32'd0);
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      #1 checkVal("ignored_busy", 32'(busy), 32'd0);
    end

    runFlush(16'h00AB);

    // asynchronous reset in the middle of a divide
    @(negedge clk);
    start = 1'b1; opcode = OP_DIV; opA = 16'd100; opB = 16'd7;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rstN = 1'b0;
    #1;
    checkVal("midrst_lo", 32'(resultLo), 32'd0);
    checkVal("midrst_hi", 32'(resultHi), 32'd0);
    checkVal("midrst_flags", 32'({done, busy, stall, divZero}), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    lastLo = '0; lastHi = '0; lastDz = 1'b0;
    runOp(OP_MUL, 16'd2, 16'd2, 0);

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = 16'd0;
        1:       rb = 16'($urandom_range(1, 15));
        2:       rb = 16'(1 << $urandom_range(0, 15));
        default: rb = 16'($urandom);
      endcase
      runOp(($urandom_range(0, 1) == 0) ? OP_MUL : OP_DIV, ra, rb, bit'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
